axi_write_buffer: RTL and testbench

Posted-store queue between the CPU data port and the AXI master's write channels. Accepts word/half/byte stores from the CPU in one cycle, holds up to DEPTH of them in a FIFO, and drains them in order as single-beat AXI write transactions (AW+W, then B). Exposes an address-conflict flag so the data read path can stall loads that hit a pending store. Also exposes an empty flag so the pipeline can wait for the queue to drain.

---
 rtl/axi_write_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_axi_write_buffer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_buffer.sv
// Posted-store queue that drains CPU stores as single-beat AXI writes.
// Entries stay queued until their B response so loads can detect conflicts.
module axi_write_buffer #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] rd_check_addr,
    output logic        rd_conflict,
    output logic        empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_B
    } state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          aw_done;
    logic          w_done;

    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];

    logic push;
    logic pop;
    logic aw_fire;
    logic w_fire;
    logic aw_next;
    logic w_next;

    assign wr_ready = (count != FULL);
    assign empty    = (count == '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = bvalid & bready;
    assign aw_fire  = awvalid & awready;
    assign w_fire   = wvalid & wready;
    assign aw_next  = aw_done | aw_fire;
    assign w_next   = w_done | w_fire;

    assign awid    = AXI_ID;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wlast   = 1'b1;

    assign awaddr = addr_q[rd_ptr];
    assign wdata  = data_q[rd_ptr];
    assign wstrb  = strb_q[rd_ptr];

    logic [2:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 4; i++) begin
            ones = ones + {2'b00, wstrb[i]};
        end
        if (ones == 3'd1) begin
            awsize = 3'd0;
        end else if (ones == 3'd2) begin
            awsize = 3'd1;
        end else begin
            awsize = 3'd2;
        end
    end

    // Entry i is live when its distance from the head is below count.
    logic [PW-1:0] off;

    always_comb begin
        rd_conflict = 1'b0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count) &&
                (addr_q[i][31:2] == rd_check_addr[31:2])) begin
                rd_conflict = 1'b1;
            end
        end
    end

    // Pushes only land in free slots, so the head is never overwritten.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= wr_addr;
            data_q[wr_ptr] <= wr_data;
            strb_q[wr_ptr] <= wr_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= ISSUE;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (aw_next && w_next) begin
                        state   <= WAIT_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        bready  <= 1'b1;
                    end else begin
                        aw_done <= aw_next;
                        w_done  <= w_next;
                        awvalid <= !aw_next;
                        wvalid  <= !w_next;
                    end
                end
                WAIT_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (count > 1) begin
                            state   <= ISSUE;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bid, bresp, rd_check_addr[1:0]};

endmodule

// File: tb/tb_axi_write_buffer.sv
// Directed bench for axi_write_buffer: per-cycle vector table plus
// hand sequences for fill, split handshake, push/pop overlap, sizing, reset.
module tb_axi_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_check_addr;
    logic        rd_conflict;
    logic        empty;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_write_buffer #(.DEPTH(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_check_addr(rd_check_addr), .rd_conflict(rd_conflict),
        .empty(empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] aw_q[$];
    int w_cnt = 0;

    typedef struct {
        logic        wv;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        awr;
        logic        wr;
        logic        bv;
        logic [31:0] rc;
        logic        e_awv;
        logic        e_wv;
        logic        e_br;
        logic        e_wrr;
        logic        e_emp;
        logic        e_conf;
        logic        pay;
        logic [31:0] e_addr;
        logic [2:0]  e_size;
        logic [3:0]  e_strb;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(
        input logic wv, input logic [31:0] a, input logic [31:0] d,
        input logic [3:0] s, input logic awr, input logic wr,
        input logic bv, input logic [31:0] rc,
        input logic e_awv, input logic e_wv, input logic e_br,
        input logic e_wrr, input logic e_emp, input logic e_conf,
        input logic pay, input logic [31:0] e_addr,
        input logic [2:0] e_size, input logic [3:0] e_strb,
        input logic [31:0] e_data);
        vec_t v;
        v.wv = wv; v.a = a; v.d = d; v.s = s;
        v.awr = awr; v.wr = wr; v.bv = bv; v.rc = rc;
        v.e_awv = e_awv; v.e_wv = e_wv; v.e_br = e_br;
        v.e_wrr = e_wrr; v.e_emp = e_emp; v.e_conf = e_conf;
        v.pay = pay; v.e_addr = e_addr; v.e_size = e_size;
        v.e_strb = e_strb; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Sample handshakes just before the edge, then move to the next negedge.
    task automatic cyc();
        #1;
        if (awvalid && awready) aw_q.push_back(awaddr);
        if (wvalid && wready) w_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        aw_q.delete();
        w_cnt = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = ~a;
        wr_strb  = s;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        wr_valid = 1'b0;
        awready  = 1'b1;
        wready   = 1'b1;
        bvalid   = 1'b1;
        #1;
        while (!empty && n < max) begin
            cyc();
            n++;
        end
        #1;
        chk(name, empty, 1'b1);
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
    endtask

    task automatic sizing(input logic [31:0] a, input logic [3:0] s,
                          input logic [2:0] exp_size);
        idle_inputs();
        push(a, s);
        cyc();
        wr_valid = 1'b0;
        cyc();
        #1;
        chk("size_awvalid", awvalid, 1'b1);
        chk("size_awsize", awsize, exp_size);
        chk("size_wstrb", wstrb, s);
        chk("size_awaddr", awaddr, a);
        drain("size_drain", 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bid = 4'd0;
        bresp = 2'd0;
        rd_check_addr = '0;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        cyc();
        #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_conflict", rd_conflict, 1'b0);
        chk("rst_const", {awid, awlen, awburst, awlock, awcache, awprot,
                          wid, wlast},
            {4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1});
        cyc();
        reset = 1'b0;

        tbl[0]  = mk(1, 32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF, 1, 1, 0,
                     32'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h1FC0_0010,
                     0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h1FC0_0013,
                     1, 1, 0, 1, 0, 1,
                     1, 32'h1FC0_0010, 3'd2, 4'hF, 32'hDEAD_BEEF);
        tbl[3]  = mk(0, 0, 0, 0, 1, 1, 1, 32'h1FC0_0010,
                     0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h1FC0_0010,
                     0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 32'h8000_0104, 32'h0000_AB00, 4'h2, 0, 0, 0,
                     32'h8000_0107, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0107,
                     0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0108,
                     1, 1, 0, 1, 0, 0,
                     1, 32'h8000_0104, 3'd0, 4'h2, 32'h0000_AB00);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h8000_0104,
                     1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0107,
                     0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0107,
                     0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0107,
                     0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            wr_valid      = tbl[i].wv;
            wr_addr       = tbl[i].a;
            wr_data       = tbl[i].d;
            wr_strb       = tbl[i].s;
            awready       = tbl[i].awr;
            wready        = tbl[i].wr;
            bvalid        = tbl[i].bv;
            rd_check_addr = tbl[i].rc;
            #1;
            chk($sformatf("v%0d_awvalid", i), awvalid, tbl[i].e_awv);
            chk($sformatf("v%0d_wvalid", i), wvalid, tbl[i].e_wv);
            chk($sformatf("v%0d_bready", i), bready, tbl[i].e_br);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, tbl[i].e_wrr);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_emp);
            chk($sformatf("v%0d_conflict", i), rd_conflict, tbl[i].e_conf);
            if (tbl[i].pay) begin
                chk($sformatf("v%0d_awaddr", i), awaddr, tbl[i].e_addr);
                chk($sformatf("v%0d_awsize", i), awsize, tbl[i].e_size);
                chk($sformatf("v%0d_wstrb", i), wstrb, tbl[i].e_strb);
                chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_data);
            end
            cyc();
        end
        rd_check_addr = '0;

        // Fill to full with a stalled slave, then full-cycle pop+push.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'h100 + 32'(i * 4), 4'hF);
            #1;
            chk($sformatf("fill%0d_wr_ready", i), wr_ready, (i < 4));
            cyc();
        end
        wr_valid = 1'b0;
        #1;
        chk("full_wr_ready", wr_ready, 1'b0);
        chk("full_awvalid", awvalid, 1'b1);
        chk("full_awaddr", awaddr, 32'h100);
        awready = 1'b1;
        wready  = 1'b1;
        cyc();
        push(32'h200, 4'hF);
        bvalid = 1'b1;
        #1;
        chk("full_pop_bready", bready, 1'b1);
        chk("full_pop_wr_ready", wr_ready, 1'b0);
        cyc();
        wr_valid = 1'b0;
        bvalid   = 1'b0;
        #1;
        chk("next_awvalid", awvalid, 1'b1);
        chk("next_awaddr", awaddr, 32'h104);
        drain("fill_drain", 60);
        chk("fill_aw_count", aw_q.size(), 4);
        chk("fill_w_count", w_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < aw_q.size()) begin
                chk($sformatf("fill_order%0d", i), aw_q[i],
                    32'h100 + 32'(i * 4));
            end
        end

        // W completes three cycles before AW.
        do_reset();
        wready = 1'b1;
        push(32'h300, 4'hF);
        cyc();
        wr_valid = 1'b0;
        cyc();
        #1;
        chk("split_awvalid0", awvalid, 1'b1);
        chk("split_wvalid0", wvalid, 1'b1);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("split%0d_wvalid", i), wvalid, 1'b0);
            chk($sformatf("split%0d_awvalid", i), awvalid, 1'b1);
            chk($sformatf("split%0d_bready", i), bready, 1'b0);
            cyc();
        end
        awready = 1'b1;
        #1;
        chk("split_aw_bready", bready, 1'b0);
        chk("split_aw_awvalid", awvalid, 1'b1);
        cyc();
        awready = 1'b0;
        bvalid  = 1'b1;
        #1;
        chk("split_waitb_bready", bready, 1'b1);
        chk("split_waitb_awvalid", awvalid, 1'b0);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("split_empty", empty, 1'b1);
        chk("split_aw_count", aw_q.size(), 1);
        chk("split_w_count", w_cnt, 1);

        // Push and pop together with two queued: occupancy stays two.
        do_reset();
        awready = 1'b1;
        wready  = 1'b1;
        push(32'h400, 4'hF);
        cyc();
        push(32'h404, 4'hF);
        cyc();
        wr_valid = 1'b0;
        cyc();
        push(32'h408, 4'hF);
        bvalid = 1'b1;
        #1;
        chk("pp_bready", bready, 1'b1);
        chk("pp_wr_ready", wr_ready, 1'b1);
        cyc();
        bvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        push(32'h40C, 4'hF);
        #1;
        chk("pp_push3_wr_ready", wr_ready, 1'b1);
        cyc();
        push(32'h410, 4'hF);
        #1;
        chk("pp_push4_wr_ready", wr_ready, 1'b1);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("pp_full_wr_ready", wr_ready, 1'b0);
        drain("pp_drain", 60);
        chk("pp_aw_count", aw_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < aw_q.size()) begin
                chk($sformatf("pp_order%0d", i), aw_q[i],
                    32'h400 + 32'(i * 4));
            end
        end

        // Size derived from strobe popcount.
        do_reset();
        sizing(32'h500, 4'h8, 3'd0);
        sizing(32'h502, 4'hC, 3'd1);
        sizing(32'h504, 4'h3, 3'd1);
        sizing(32'h508, 4'h5, 3'd1);
        sizing(32'h50C, 4'h7, 3'd2);
        sizing(32'h510, 4'hF, 3'd2);

        // Reset while waiting for B.
        do_reset();
        awready = 1'b1;
        wready  = 1'b1;
        push(32'h600, 4'hF);
        cyc();
        push(32'h604, 4'hF);
        cyc();
        wr_valid = 1'b0;
        cyc();
        rd_check_addr = 32'h600;
        #1;
        chk("rstb_bready_pre", bready, 1'b1);
        chk("rstb_conflict_pre", rd_conflict, 1'b1);
        reset = 1'b1;
        cyc();
        #1;
        chk("rstb_bready", bready, 1'b0);
        chk("rstb_empty", empty, 1'b1);
        chk("rstb_wr_ready", wr_ready, 1'b1);
        chk("rstb_awvalid", awvalid, 1'b0);
        chk("rstb_conflict", rd_conflict, 1'b0);
        reset = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rstb_idle_awvalid", awvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
